// File: rtl/uart_param.sv
// uart_param: single-clock UART transceiver with build-time frame format.
// A shared divider produces the 16x oversampling tick for the receiver.
// The transmitter keeps its own bit-phase counter, which restarts on every
// accepted load, so that each transmitted bit lasts exactly 16*CLK_DIV cycles.
// The receiver reports framing, parity and overrun errors alongside each word.
module uart_param #(
  parameter int CLK_DIV   = 4,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ld_tx_data,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_enable,
  output logic                 tx_out,
  output logic                 tx_empty,
  input  logic                 uld_rx_data,
  output logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_enable,
  input  logic                 rx_in,
  output logic                 rx_empty,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);

  localparam int BIT_CYC = 16 * CLK_DIV;
  localparam int CW      = $clog2(BIT_CYC);
  localparam int DW      = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] BIT_PRE   = CW'(BIT_CYC - 2);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [2:0]    IDX_DLAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    IDX_SLAST = 3'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  // ---------------------------------------------------------------------------
  // Oversampling tick
  // ---------------------------------------------------------------------------
  logic [DW-1:0] div_cnt;
  logic          tick;

  assign tick = (div_cnt == DIV_LAST);

  // Free-running modulo-CLK_DIV divider.
  always_ff @(posedge clk) begin
    if (!reset_n)  div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  state_t               tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [2:0]           tx_idx;
  logic [DATA_BITS-1:0] tx_shreg;
  logic                 tx_par;
  logic                 tx_bit_end, tx_last_stop, tx_load, tx_start;

  assign tx_bit_end   = (tx_cnt == BIT_LAST);
  assign tx_last_stop = (tx_state == S_STOP) && (tx_idx == IDX_SLAST);
  assign tx_load      = ld_tx_data && tx_empty && tx_enable;
  // tx_empty is already high in the final stop cycle, so a load presented
  // then begins the next start bit with no idle gap.
  assign tx_start     = tx_load && ((tx_state == S_IDLE) || (tx_last_stop && tx_bit_end));

  // TX frame sequencer: start, data LSB first, optional parity, stop bits.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shreg <= '0;
      tx_par   <= 1'b0;
      tx_out   <= 1'b1;
      tx_empty <= 1'b1;
    end else if (tx_start) begin
      tx_shreg <= tx_data;
      tx_par   <= (^tx_data) ^ ODD;
      tx_empty <= 1'b0;
      tx_out   <= 1'b0;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_state <= S_START;
    end else if (tx_state != S_IDLE) begin
      tx_cnt <= tx_bit_end ? '0 : tx_cnt + 1'b1;
      if (tx_last_stop && tx_cnt == BIT_PRE) tx_empty <= 1'b1;
      if (tx_bit_end) begin
        case (tx_state)
          S_START: begin
            tx_state <= S_DATA;
            tx_out   <= tx_shreg[0];
          end
          S_DATA: begin
            if (tx_idx == IDX_DLAST) begin
              tx_idx <= '0;
              if (PARITY != 0) begin
                tx_state <= S_PAR;
                tx_out   <= tx_par;
              end else begin
                tx_state <= S_STOP;
                tx_out   <= 1'b1;
              end
            end else begin
              tx_idx   <= tx_idx + 1'b1;
              tx_shreg <= tx_shreg >> 1;
              tx_out   <= tx_shreg[1];
            end
          end
          S_PAR: begin
            tx_state <= S_STOP;
            tx_out   <= 1'b1;
          end
          S_STOP: begin
            if (tx_idx == IDX_SLAST) tx_state <= S_IDLE;
            else                     tx_idx   <= tx_idx + 1'b1;
          end
          default: tx_state <= S_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic [1:0]           rx_sync;
  logic                 rx_s;
  state_t               rx_state;
  logic [3:0]           rx_tick;
  logic [2:0]           rx_idx;
  logic [DATA_BITS-1:0] rx_shreg;
  logic                 rx_perr;
  logic                 rx_done;

  assign rx_s    = rx_sync[1];
  assign rx_done = rx_enable && tick && (rx_state == S_STOP) && (rx_tick == 4'd15);

  // RX synchroniser, mid-bit sampler and host-side word/flag holding.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_sync       <= 2'b11;
      rx_state      <= S_IDLE;
      rx_tick       <= '0;
      rx_idx        <= '0;
      rx_shreg      <= '0;
      rx_perr       <= 1'b0;
      rx_data       <= '0;
      rx_empty      <= 1'b1;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], rx_in};

      // A completing word takes priority over a same-cycle unload.
      if (rx_done) begin
        rx_data       <= rx_shreg;
        rx_empty      <= 1'b0;
        rx_frame_err  <= ~rx_s;
        rx_parity_err <= rx_perr;
        rx_overrun    <= ~rx_empty & ~uld_rx_data;
      end else if (uld_rx_data && !rx_empty) begin
        rx_empty      <= 1'b1;
        rx_frame_err  <= 1'b0;
        rx_parity_err <= 1'b0;
        rx_overrun    <= 1'b0;
      end

      if (!rx_enable) begin
        rx_state <= S_IDLE;
        rx_tick  <= '0;
      end else if (tick) begin
        case (rx_state)
          S_IDLE: begin
            if (!rx_s) begin
              rx_state <= S_START;
              rx_tick  <= '0;
            end
          end
          // Half a bit after the falling edge: a high line is a glitch.
          S_START: begin
            if (rx_tick == 4'd7) begin
              rx_tick  <= '0;
              rx_idx   <= '0;
              rx_state <= rx_s ? S_IDLE : S_DATA;
            end else begin
              rx_tick <= rx_tick + 1'b1;
            end
          end
          default: begin
            rx_tick <= rx_tick + 1'b1;
            if (rx_tick == 4'd15) begin
              case (rx_state)
                S_DATA: begin
                  rx_shreg <= {rx_s, rx_shreg[DATA_BITS-1:1]};
                  if (rx_idx == IDX_DLAST) begin
                    rx_idx   <= '0;
                    rx_state <= (PARITY != 0) ? S_PAR : S_STOP;
                  end else begin
                    rx_idx <= rx_idx + 1'b1;
                  end
                end
                S_PAR: begin
                  rx_perr  <= (^rx_shreg) ^ rx_s ^ ODD;
                  rx_state <= S_STOP;
                end
                default: rx_state <= S_IDLE;
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_param.sv
// tb_uart_param: two instances (8N1 at CLK_DIV=4, 7O2 at CLK_DIV=2) driven
// with random words; frames are predicted from the bit-level frame format.
module tb_uart_param;
  localparam int BA = 64;  // bit time of instance A
  localparam int BB = 32;  // bit time of instance B

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic       ld_a = 0, txen_a = 1, uld_a = 0, rxen_a = 1, loop_a = 1, drv_a = 1;
  logic [7:0] txd_a = '0, rxd_a;
  logic       tx_out_a, tx_empty_a, rx_in_a, rx_empty_a, fe_a, pe_a, ov_a;
  logic       ld_b = 0, txen_b = 1, uld_b = 0, rxen_b = 1, loop_b = 1, drv_b = 1;
  logic [6:0] txd_b = '0, rxd_b;
  logic       tx_out_b, tx_empty_b, rx_in_b, rx_empty_b, fe_b, pe_b, ov_b;

  assign rx_in_a = loop_a ? tx_out_a : drv_a;
  assign rx_in_b = loop_b ? tx_out_b : drv_b;

  uart_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .reset_n(reset_n), .ld_tx_data(ld_a), .tx_data(txd_a),
    .tx_enable(txen_a), .tx_out(tx_out_a), .tx_empty(tx_empty_a),
    .uld_rx_data(uld_a), .rx_data(rxd_a), .rx_enable(rxen_a), .rx_in(rx_in_a),
    .rx_empty(rx_empty_a), .rx_frame_err(fe_a), .rx_parity_err(pe_a), .rx_overrun(ov_a));

  uart_param #(.CLK_DIV(2), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_b (
    .clk(clk), .reset_n(reset_n), .ld_tx_data(ld_b), .tx_data(txd_b),
    .tx_enable(txen_b), .tx_out(tx_out_b), .tx_empty(tx_empty_b),
    .uld_rx_data(uld_b), .rx_data(rxd_b), .rx_enable(rxen_b), .rx_in(rx_in_b),
    .rx_empty(rx_empty_b), .rx_frame_err(fe_b), .rx_parity_err(pe_b), .rx_overrun(ov_b));

  int checks = 0, failures = 0;

  // length of the most recent completed high run on tx_out_a
  int hi_run = 0, last_hi = 0;
  always @(posedge clk) begin
    if (tx_out_a === 1'b1) hi_run <= hi_run + 1;
    else begin
      if (hi_run != 0) last_hi <= hi_run;
      hi_run <= 0;
    end
  end

  // Frame as line levels, bit 0 first: start 0, data LSB first, parity, stops (1s).
  function automatic logic [15:0] mk_frame(input logic [7:0] d, input int dbits, input int par);
    logic [15:0] f;
    int n, ones;
    f = '1; f[0] = 1'b0; n = 1; ones = 0;
    for (int i = 0; i < dbits; i++) begin
      f[n] = d[i];
      ones += int'(d[i]);
      n++;
    end
    if (par != 0) f[n] = ((ones % 2 == 1) == (par == 2));
    return f;
  endfunction

  task automatic load(input bit b, input logic [7:0] d);
    @(negedge clk);
    if (b) begin ld_b = 1; txd_b = d[6:0]; end
    else   begin ld_a = 1; txd_a = d;      end
    @(negedge clk);
    ld_a = 0; ld_b = 0;
  endtask

  task automatic unload(input bit b);
    @(negedge clk);
    if (b) uld_b = 1; else uld_a = 1;
    @(negedge clk);
    uld_a = 0; uld_b = 0;
  endtask

  task automatic wait_rx(input bit b, input int maxc, output bit ok);
    ok = 0;
    for (int i = 0; i < maxc; i++) begin
      if ((b ? rx_empty_b : rx_empty_a) === 1'b0) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_txe(input bit b, input logic val, input int maxc, output bit ok);
    ok = 0;
    for (int i = 0; i < maxc; i++) begin
      if ((b ? tx_empty_b : tx_empty_a) === val) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  // Find the start bit on tx_out and sample each bit near its middle.
  task automatic decode(input bit b, input int n, output logic [15:0] got, output bit ok);
    int bc;
    bc = b ? BB : BA; got = '1; ok = 0;
    for (int i = 0; i < 4 * bc; i++) begin
      @(negedge clk);
      if ((b ? tx_out_b : tx_out_a) === 1'b0) begin ok = 1; break; end
    end
    if (ok) begin
      repeat (bc / 2) @(negedge clk);
      got[0] = b ? tx_out_b : tx_out_a;
      for (int k = 1; k < n; k++) begin
        repeat (bc) @(negedge clk);
        got[k] = b ? tx_out_b : tx_out_a;
      end
    end
  endtask

  task automatic drive_bits(input bit b, input logic [15:0] f, input int n, input int lastlen);
    int bc;
    bc = b ? BB : BA;
    for (int k = 0; k < n; k++) begin
      if (b) drv_b = f[k]; else drv_a = f[k];
      repeat ((k == n - 1) ? lastlen : bc) @(negedge clk);
    end
    drv_a = 1; drv_b = 1;
  endtask

  task automatic test_reset;
    reset_n = 0;
    repeat (3) @(negedge clk);
    checks += 4;
    if ({tx_out_a, tx_empty_a, rx_empty_a, fe_a, pe_a, ov_a} !== 6'b111000) begin
      failures++; $display("FAIL reset_a_flags got=%b exp=111000", {tx_out_a, tx_empty_a, rx_empty_a, fe_a, pe_a, ov_a});
    end
    if (rxd_a !== 8'h00) begin failures++; $display("FAIL reset_a_data got=%h exp=00", rxd_a); end
    if ({tx_out_b, tx_empty_b, rx_empty_b, fe_b, pe_b, ov_b} !== 6'b111000) begin
      failures++; $display("FAIL reset_b_flags got=%b exp=111000", {tx_out_b, tx_empty_b, rx_empty_b, fe_b, pe_b, ov_b});
    end
    if (rxd_b !== 7'h00) begin failures++; $display("FAIL reset_b_data got=%h exp=00", rxd_b); end
    reset_n = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tx_enable;
    txen_a = 0;
    load(0, 8'h5A);
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_empty_a, tx_out_a} !== 2'b11) begin
      failures++; $display("FAIL tx_enable_block got=%b exp=11", {tx_empty_a, tx_out_a});
    end
    txen_a = 1;
  endtask

  task automatic test_loopback;
    logic [7:0] d; logic [15:0] exp, got; bit ok;
    for (int it = 0; it < 3; it++) begin
      d = 8'($urandom);
      exp = mk_frame(d, 8, 0);
      wait_txe(0, 1'b1, 12 * BA, ok);
      load(0, d);
      decode(0, 10, got, ok);
      checks++;
      if (!ok || got[9:0] !== exp[9:0]) begin
        failures++; $display("FAIL tx_wave got=%b exp=%b ok=%0d", got[9:0], exp[9:0], ok);
      end
      wait_rx(0, 2 * BA, ok);
      checks += 2;
      if (!ok || rxd_a !== d) begin failures++; $display("FAIL loop_data got=%h exp=%h", rxd_a, d); end
      if ({fe_a, pe_a, ov_a} !== 3'b000) begin failures++; $display("FAIL loop_flags got=%b exp=000", {fe_a, pe_a, ov_a}); end
      unload(0);
      checks++;
      if (rx_empty_a !== 1'b1) begin failures++; $display("FAIL loop_unload got=%b exp=1", rx_empty_a); end
    end
  endtask

  task automatic test_back_to_back;
    bit ok, ok2;
    wait_txe(0, 1'b1, 12 * BA, ok);
    @(negedge clk);
    ld_a = 1; txd_a = 8'hAA;
    wait_txe(0, 1'b0, 4, ok);
    txd_a = 8'hB4;
    wait_txe(0, 1'b1, 12 * BA, ok2);
    ok = ok & ok2;
    @(negedge clk);
    wait_txe(0, 1'b0, 4, ok2);
    ok = ok & ok2;
    ld_a = 0;
    repeat (2) @(negedge clk);
    checks += 2;
    if (!ok || last_hi != 2 * BA) begin
      failures++; $display("FAIL b2b_gap got=%0d exp=%0d ok=%0d", last_hi, 2 * BA, ok);
    end
    if (rx_empty_a !== 1'b0 || rxd_a !== 8'hAA) begin
      failures++; $display("FAIL b2b_first got=%h empty=%b exp=aa", rxd_a, rx_empty_a);
    end
    unload(0);
    wait_rx(0, 12 * BA, ok);
    checks++;
    if (!ok || rxd_a !== 8'hB4 || {fe_a, pe_a, ov_a} !== 3'b000) begin
      failures++; $display("FAIL b2b_second got=%h flags=%b exp=b4/000", rxd_a, {fe_a, pe_a, ov_a});
    end
    unload(0);
    wait_txe(0, 1'b1, 12 * BA, ok);
    repeat (4) @(negedge clk);
    checks++;
    if (tx_out_a !== 1'b1) begin failures++; $display("FAIL b2b_idle got=%b exp=1", tx_out_a); end
  endtask

  task automatic test_false_start_frame_err;
    logic [7:0] d; logic [15:0] f;
    loop_a = 0; drv_a = 1;
    @(negedge clk);
    drv_a = 0;
    repeat (16) @(negedge clk);
    drv_a = 1;
    repeat (2 * BA) @(negedge clk);
    checks++;
    if (rx_empty_a !== 1'b1) begin failures++; $display("FAIL false_start got=%b exp=1", rx_empty_a); end
    d = 8'($urandom);
    f = mk_frame(d, 8, 0);
    f[9] = 1'b0;
    drive_bits(0, f, 10, 3 * BA / 4);
    repeat (4) @(negedge clk);
    checks += 2;
    if (rx_empty_a !== 1'b0 || rxd_a !== d) begin
      failures++; $display("FAIL frame_err_data got=%h empty=%b exp=%h", rxd_a, rx_empty_a, d);
    end
    if ({fe_a, pe_a, ov_a} !== 3'b100) begin
      failures++; $display("FAIL frame_err_flag got=%b exp=100", {fe_a, pe_a, ov_a});
    end
    unload(0);
    checks++;
    if ({rx_empty_a, fe_a, pe_a, ov_a} !== 4'b1000) begin
      failures++; $display("FAIL frame_err_clear got=%b exp=1000", {rx_empty_a, fe_a, pe_a, ov_a});
    end
    repeat (BA) @(negedge clk);
    loop_a = 1;
  endtask

  task automatic test_overrun;
    logic [7:0] w1, w2; bit ok;
    w1 = 8'($urandom); w2 = 8'($urandom);
    wait_txe(0, 1'b1, 12 * BA, ok);
    load(0, w1);
    wait_txe(0, 1'b1, 12 * BA, ok);
    checks++;
    if (!ok || rx_empty_a !== 1'b0 || rxd_a !== w1 || ov_a !== 1'b0) begin
      failures++; $display("FAIL ovr_first got=%h ov=%b exp=%h/0", rxd_a, ov_a, w1);
    end
    load(0, w2);
    wait_txe(0, 1'b1, 12 * BA, ok);
    repeat (4) @(negedge clk);
    checks += 2;
    if (!ok || rxd_a !== w2 || rx_empty_a !== 1'b0) begin
      failures++; $display("FAIL ovr_data got=%h exp=%h", rxd_a, w2);
    end
    if ({fe_a, pe_a, ov_a} !== 3'b001) begin
      failures++; $display("FAIL ovr_flag got=%b exp=001", {fe_a, pe_a, ov_a});
    end
    unload(0);
    checks++;
    if ({rx_empty_a, fe_a, pe_a, ov_a} !== 4'b1000) begin
      failures++; $display("FAIL ovr_clear got=%b exp=1000", {rx_empty_a, fe_a, pe_a, ov_a});
    end
  endtask

  task automatic test_parity_b;
    logic [7:0] d; logic [15:0] f, got; bit ok, flip, hi;
    f = mk_frame(8'h3C, 7, 1);
    load(1, 8'h3C);
    decode(1, 11, got, ok);
    checks += 2;
    if (!ok || got[10:0] !== f[10:0]) begin
      failures++; $display("FAIL b_wave got=%b exp=%b", got[10:0], f[10:0]);
    end
    if (tx_empty_b !== 1'b0) begin failures++; $display("FAIL b_stop_busy got=%b exp=0", tx_empty_b); end
    hi = 1;
    ok = 0;
    for (int i = 0; i < BB; i++) begin
      if (tx_empty_b === 1'b1) begin ok = 1; break; end
      hi &= tx_out_b;
      @(negedge clk);
    end
    checks++;
    if (!ok || !hi) begin failures++; $display("FAIL b_stop_end empty_ok=%0d high=%0d exp=1/1", ok, hi); end
    wait_rx(1, 2 * BB, ok);
    checks++;
    if (!ok || rxd_b !== 7'h3C || {fe_b, pe_b, ov_b} !== 3'b000) begin
      failures++; $display("FAIL b_loop got=%h flags=%b exp=3c/000", rxd_b, {fe_b, pe_b, ov_b});
    end
    unload(1);
    loop_b = 0;
    for (int it = 0; it < 4; it++) begin
      d = 8'($urandom) & 8'h7F;
      flip = it[0];
      f = mk_frame(d, 7, 1);
      if (flip) f[8] = ~f[8];
      drive_bits(1, f, 11, BB);
      checks += 2;
      if (rx_empty_b !== 1'b0 || rxd_b !== d[6:0]) begin
        failures++; $display("FAIL b_inj_data got=%h exp=%h", rxd_b, d[6:0]);
      end
      if ({fe_b, pe_b, ov_b} !== {1'b0, flip, 1'b0}) begin
        failures++; $display("FAIL b_inj_parity got=%b exp=%b", {fe_b, pe_b, ov_b}, {1'b0, flip, 1'b0});
      end
      unload(1);
    end
    loop_b = 1;
  endtask

  task automatic test_reset_mid;
    logic [7:0] w0, w1, w2; bit ok;
    w0 = 8'($urandom) | 8'h01; w1 = 8'($urandom); w2 = 8'($urandom);
    wait_txe(0, 1'b1, 12 * BA, ok);
    load(0, w0);
    wait_txe(0, 1'b1, 12 * BA, ok);
    load(0, w1);
    repeat (3 * BA + BA / 2) @(negedge clk);
    checks++;
    if (tx_empty_a !== 1'b0 || rx_empty_a !== 1'b0 || rxd_a !== w0) begin
      failures++; $display("FAIL mid_pre got=%h txe=%b rxe=%b exp=%h/0/0", rxd_a, tx_empty_a, rx_empty_a, w0);
    end
    reset_n = 0;
    @(negedge clk);
    checks += 2;
    if ({tx_out_a, tx_empty_a, rx_empty_a, fe_a, pe_a, ov_a} !== 6'b111000) begin
      failures++; $display("FAIL mid_reset_flags got=%b exp=111000", {tx_out_a, tx_empty_a, rx_empty_a, fe_a, pe_a, ov_a});
    end
    if (rxd_a !== 8'h00) begin failures++; $display("FAIL mid_reset_data got=%h exp=00", rxd_a); end
    reset_n = 1;
    load(0, w2);
    wait_rx(0, 12 * BA, ok);
    checks++;
    if (!ok || rxd_a !== w2 || {fe_a, pe_a, ov_a} !== 3'b000) begin
      failures++; $display("FAIL mid_after got=%h flags=%b exp=%h/000", rxd_a, {fe_a, pe_a, ov_a}, w2);
    end
    unload(0);
  endtask

  initial begin
    test_reset();
    test_tx_enable();
    test_loopback();
    test_back_to_back();
    test_false_start_frame_err();
    test_overrun();
    test_parity_b();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
